// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// master: operand source and result consumer; slave: the ALU itself.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         opcode;
    logic               mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] outALU;
    logic               za;
    logic               zb;
    logic               eq;
    logic               gt;
    logic               lt;
    logic               dz;

    modport master (
        output in_valid, a, b, opcode, mode, out_ready,
        input  in_ready, out_valid, outALU, za, zb, eq, gt, lt, dz
    );

    modport slave (
        input  in_valid, a, b, opcode, mode, out_ready,
        output in_ready, out_valid, outALU, za, zb, eq, gt, lt, dz
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential arithmetic/logic unit with valid/ready on both sides.
// Single-cycle ops, shift-add multiply (WIDTH iterations) and, when the
// ALU_DIV_EN macro is defined, a restoring divider (WIDTH iterations).
// Without ALU_DIV_EN, mode0 op 011 finishes in one cycle with outALU=0, dz=1.
// Every result passes through FIN, which loads the output registers, so
// out_valid rises one edge after the operation's work is complete.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = CNT_W - 1;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_p0;
    logic [WIDTH-1:0]   b_p0;
    logic [2:0]         op_p0;
    logic               mode_p0;
    logic [2*WIDTH-1:0] wk_p1;
    logic [CNT_W-1:0]   cnt;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [2*WIDTH-1:0] res_r;
    logic               za_r, zb_r, eq_r, gt_r, lt_r, dz_r;
    logic [2*WIDTH-1:0] res_nxt;
    logic               dz_nxt;
    logic               is_mul;
    logic               is_div;

    // One-cycle operations; results zero-extended, bit WIDTH holds carry/borrow.
    function automatic logic [2*WIDTH-1:0] alu_single(
        input logic [2:0]       op,
        input logic             md,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0]     s;
        logic [WIDTH-1:0]   l;
        logic [2*WIDTH-1:0] r;
        s = '0;
        l = '0;
        if (!md) begin
            case (op)
                3'b000:  s = {1'b0, x} + {1'b0, y};
                3'b001:  s = {1'b0, x} - {1'b0, y};
                3'b100:  s = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
                3'b101:  s = {1'b0, x} - {{WIDTH{1'b0}}, 1'b1};
                3'b110:  s = {1'b0, y} - {1'b0, x};
                3'b111:  s = {1'b0, x};
                default: s = '0;
            endcase
            r = {{(WIDTH-1){1'b0}}, s};
        end else begin
            case (op)
                3'b000:  l = x & y;
                3'b001:  l = x | y;
                3'b010:  l = x ^ y;
                3'b011:  l = ~(x & y);
                3'b100:  l = ~(x | y);
                3'b101:  l = ~(x ^ y);
                default: l = ~x;
            endcase
            if (op == 3'b111) r = {{WIDTH{1'b0}}, x} << y[SH_W-1:0];
            else              r = {{WIDTH{1'b0}}, l};
        end
        return r;
    endfunction

    // Shift-add step: upper half accumulates, lower half shifts out multiplier bits.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] wk,
        input logic [WIDTH-1:0]   x
    );
        logic [WIDTH:0] s;
        s = {1'b0, wk[2*WIDTH-1:WIDTH]} + (wk[0] ? {1'b0, x} : '0);
        return {s, wk[WIDTH-1:1]};
    endfunction

`ifdef ALU_DIV_EN
    // Restoring step: {remainder, quotient}; a zero divisor naturally yields
    // an all-ones quotient and the dividend as remainder.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [2*WIDTH-1:0] wk,
        input logic [WIDTH-1:0]   y
    );
        logic [WIDTH:0] sh;
        logic [WIDTH:0] d;
        sh = wk[2*WIDTH-1:WIDTH-1];
        d  = sh - {1'b0, y};
        if (sh >= {1'b0, y}) return {d[WIDTH-1:0], wk[WIDTH-2:0], 1'b1};
        else                 return {sh[WIDTH-1:0], wk[WIDTH-2:0], 1'b0};
    endfunction
`endif

    assign is_mul = !mode_p0 && (op_p0 == 3'b010);
    assign is_div = !mode_p0 && (op_p0 == 3'b011);

    // Select the value loaded into the output registers in FIN.
    always_comb begin
        res_nxt = alu_single(op_p0, mode_p0, a_p0, b_p0);
        dz_nxt  = 1'b0;
        if (is_mul) res_nxt = wk_p1;
`ifdef ALU_DIV_EN
        if (is_div) begin
            res_nxt = wk_p1;
            dz_nxt  = (b_p0 == '0);
        end
`else
        if (is_div) begin
            res_nxt = '0;
            dz_nxt  = 1'b1;
        end
`endif
    end

    // Control FSM with operand latch, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            res_r       <= '0;
            {za_r, zb_r, eq_r, gt_r, lt_r, dz_r} <= '0;
            a_p0        <= '0;
            b_p0        <= '0;
            op_p0       <= '0;
            mode_p0     <= 1'b0;
            wk_p1       <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                // operand accept stage
                IDLE: begin
                    if (bus.in_valid) begin
                        a_p0       <= bus.a;
                        b_p0       <= bus.b;
                        op_p0      <= bus.opcode;
                        mode_p0    <= bus.mode;
                        in_ready_r <= 1'b0;
                        cnt        <= CNT_W'(WIDTH - 1);
                        if (!bus.mode && bus.opcode == 3'b010) begin
                            wk_p1 <= {{WIDTH{1'b0}}, bus.b};
                            state <= MUL;
                        end
`ifdef ALU_DIV_EN
                        else if (!bus.mode && bus.opcode == 3'b011) begin
                            wk_p1 <= {{WIDTH{1'b0}}, bus.a};
                            state <= DIV;
                        end
`endif
                        else begin
                            state <= FIN;
                        end
                    end
                end
                // iteration stage
                MUL: begin
                    wk_p1 <= mul_step(wk_p1, a_p0);
                    if (cnt == '0) state <= FIN;
                    else           cnt   <= cnt - CNT_W'(1);
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    wk_p1 <= div_step(wk_p1, b_p0);
                    if (cnt == '0) state <= FIN;
                    else           cnt   <= cnt - CNT_W'(1);
                end
`endif
                // output register stage
                FIN: begin
                    res_r       <= res_nxt;
                    dz_r        <= dz_nxt;
                    za_r        <= (a_p0 == '0);
                    zb_r        <= (b_p0 == '0);
                    eq_r        <= (a_p0 == b_p0);
                    gt_r        <= (a_p0 > b_p0);
                    lt_r        <= (a_p0 < b_p0);
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.outALU    = res_r;
    assign bus.za        = za_r;
    assign bus.zb        = zb_r;
    assign bus.eq        = eq_r;
    assign bus.gt        = gt_r;
    assign bus.lt        = lt_r;
    assign bus.dz        = dz_r;
endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=16). Honours the ALU_DIV_EN macro the same way
// the design does.
module tb_seq_alu;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [37:0] val;   // {outALU, za, zb, eq, gt, lt, dz}
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    logic prev_ov = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Reference behaviour computed with plain 64-bit arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic md,
                                   input logic [15:0] x, input logic [15:0] y);
        logic [63:0] X, Y, r;
        logic [15:0] t;
        logic        d;
        exp_t        e;
        X = {48'h0, x};
        Y = {48'h0, y};
        r = 0;
        d = 1'b0;
        e.lat = 1;
        if (!md) begin
            case (op)
                3'd0: r = X + Y;
                3'd1: r = (X - Y) & 64'h1FFFF;
                3'd2: begin r = X * Y; e.lat = W + 1; end
                3'd3: begin
`ifdef ALU_DIV_EN
                    e.lat = W + 1;
                    d = (y == 0);
                    if (y == 0) r = (X << 16) | 64'hFFFF;
                    else        r = ((X % Y) << 16) | (X / Y);
`else
                    r = 0;
                    d = 1'b1;
`endif
                end
                3'd4: r = X + 1;
                3'd5: r = (X - 1) & 64'h1FFFF;
                3'd6: r = (Y - X) & 64'h1FFFF;
                default: r = X;
            endcase
        end else begin
            case (op)
                3'd0: t = x & y;
                3'd1: t = x | y;
                3'd2: t = x ^ y;
                3'd3: t = ~(x & y);
                3'd4: t = ~(x | y);
                3'd5: t = ~(x ^ y);
                default: t = ~x;
            endcase
            r = (op == 3'd7) ? (X << (y % 16)) : {48'h0, t};
        end
        e.val = {r[31:0], x == 0, y == 0, x == y, x > y, x < y, d};
        e.acc = 0;
        return e;
    endfunction

    // Scoreboard: queue expectations at accept, check every valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.opcode, bus.mode, bus.a, bus.b);
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got outALU=%h with nothing pending", bus.outALU);
                end else begin
                    if (!prev_ov) check("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                    check("model", {26'h0, bus.outALU, bus.za, bus.zb, bus.eq, bus.gt, bus.lt, bus.dz},
                          {26'h0, exp_q[0].val});
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    // Issue one operation, optionally stall the consumer, check literal results.
    task automatic do_op(input string nm, input logic [2:0] op, input logic md,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] lit, input logic [5:0] fl, input int hold);
        int n;
        @(posedge clk); #1;
        bus.opcode = op; bus.mode = md; bus.a = x; bus.b = y;
        bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) check({nm, "_accept_timeout"}, 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        if (!bus.out_valid) check({nm, "_valid_timeout"}, 0, 1);
        check({nm, "_result"}, 64'(bus.outALU), 64'(lit));
        check({nm, "_flags"}, 64'({bus.za, bus.zb, bus.eq, bus.gt, bus.lt, bus.dz}), 64'(fl));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check({nm, "_hold_valid"}, 64'(bus.out_valid), 1);
                check({nm, "_hold_in_ready"}, 64'(bus.in_ready), 0);
                check({nm, "_hold_result"}, 64'(bus.outALU), 64'(lit));
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
        end
        n = 0;
        while (bus.out_valid && n < 50) begin @(negedge clk); n++; end
        check({nm, "_in_ready_after"}, 64'(bus.in_ready), 1);
    endtask

    initial begin
        int seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.opcode = '0; bus.mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_outALU", 64'(bus.outALU), 0);
        check("rst_flags", 64'({bus.za, bus.zb, bus.eq, bus.gt, bus.lt, bus.dz}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 1);

        do_op("add", 3'b000, 1'b0, 16'hFFFF, 16'h0001, 32'h00010000, 6'b000100, 0);

        // Abort a multiply with an asynchronous reset.
        @(posedge clk); #1;
        bus.opcode = 3'b010; bus.mode = 1'b0; bus.a = 16'h1234; bus.b = 16'h5678;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 0);
        check("abort_outALU", 64'(bus.outALU), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(bus.in_ready), 1);
        seen = 0;
        repeat (25) begin @(negedge clk); if (bus.out_valid) seen++; end
        check("abort_no_stale", 64'(seen), 0);

        do_op("mul", 3'b010, 1'b0, 16'h0100, 16'h0110, 32'h00011000, 6'b000010, 0);
        do_op("mul_max", 3'b010, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 6'b001000, 0);
`ifdef ALU_DIV_EN
        do_op("div", 3'b011, 1'b0, 16'h00E9, 16'h0007, 32'h00020021, 6'b000100, 0);
        do_op("div0", 3'b011, 1'b0, 16'h0003, 16'h0000, 32'h0003FFFF, 6'b010101, 0);
`else
        do_op("div", 3'b011, 1'b0, 16'h00E9, 16'h0007, 32'h00000000, 6'b000101, 0);
        do_op("div0", 3'b011, 1'b0, 16'h0003, 16'h0000, 32'h00000000, 6'b010101, 0);
`endif
        do_op("xnor_bp", 3'b101, 1'b1, 16'h00E9, 16'h00E9, 32'h0000FFFF, 6'b001000, 5);
        do_op("sub_borrow", 3'b001, 1'b0, 16'h0001, 16'h0002, 32'h0001FFFF, 6'b000010, 0);
        do_op("dec_zero", 3'b101, 1'b0, 16'h0000, 16'h0000, 32'h0001FFFF, 6'b111000, 0);
        do_op("b_minus_a", 3'b110, 1'b0, 16'h0005, 16'h0003, 32'h0001FFFE, 6'b000100, 0);
        do_op("inc_wrap", 3'b100, 1'b0, 16'hFFFF, 16'h0000, 32'h00010000, 6'b010100, 0);
        do_op("pass", 3'b111, 1'b0, 16'h1234, 16'h0000, 32'h00001234, 6'b010100, 0);
        do_op("add_zero", 3'b000, 1'b0, 16'h0000, 16'h0000, 32'h00000000, 6'b111000, 0);
        do_op("and", 3'b000, 1'b1, 16'hF0F0, 16'h3C3C, 32'h00003030, 6'b000100, 0);
        do_op("or", 3'b001, 1'b1, 16'hF0F0, 16'h3C3C, 32'h0000FCFC, 6'b000100, 0);
        do_op("xor", 3'b010, 1'b1, 16'hF0F0, 16'h3C3C, 32'h0000CCCC, 6'b000100, 0);
        do_op("nand", 3'b011, 1'b1, 16'hF0F0, 16'h3C3C, 32'h0000CFCF, 6'b000100, 0);
        do_op("nor", 3'b100, 1'b1, 16'hF0F0, 16'h3C3C, 32'h00000303, 6'b000100, 0);
        do_op("not_a", 3'b110, 1'b1, 16'hF0F0, 16'h3C3C, 32'h00000F0F, 6'b000100, 0);
        do_op("shl", 3'b111, 1'b1, 16'hFFFF, 16'h000F, 32'h7FFF8000, 6'b000100, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
